ex_dm_pipe_reg: RTL

Parametrised, elastic EX→DM pipeline register that replaces the fixed 32-bit always-load stage latch. It carries the ALU result (memory address), store data and memory/write-back control from execute to data memory. It adds a valid/ready handshake with a one-entry skid buffer, synchronous flush, and registered byte-enable/misalignment generation for byte/half/word accesses. It sits between the ALU output and the data-memory port, with hazard/branch logic driving `flush`.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/skid_slot.sv | 31 +++
 rtl/ex_dm_pipe_reg.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared EX/DM definitions: access-size encodings, control bundle and
// the lane-mask / natural-alignment helpers used at beat capture.
package cpu_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2,
      MEM_RSVD = 2'd3
   } mem_size_e;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
   } ctrl_t;

   // Helpers are sized for the widest supported datapath (1024 bits);
   // callers truncate the mask to their own lane count.
   localparam int MAX_BE_W   = 128;
   localparam int LANE_IDX_W = 7;

   function automatic logic [MAX_BE_W-1:0] byte_enable(
      input mem_size_e             size,
      input logic [LANE_IDX_W-1:0] lane
   );
      logic [MAX_BE_W-1:0] mask;
      mask = {MAX_BE_W{1'b0}};
      case (size)
         MEM_BYTE: mask = 128'd1 << lane;
         MEM_HALF: mask = 128'd3 << lane;
         // Word lanes start on the enclosing 4-byte boundary.
         MEM_WORD: mask = 128'hF << {lane[LANE_IDX_W-1:2], 2'b00};
         default:  mask = {MAX_BE_W{1'b0}};
      endcase
      return mask;
   endfunction

   function automatic logic access_misaligned(
      input mem_size_e             size,
      input logic [LANE_IDX_W-1:0] lane
   );
      logic mis;
      mis = 1'b1;
      case (size)
         MEM_BYTE: mis = 1'b0;
         MEM_HALF: mis = lane[0];
         MEM_WORD: mis = |lane[1:0];
         default:  mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/skid_slot.sv
// One payload register with a valid bit; clear wins over load, and the
// payload holds its value when cleared.
module skid_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   // Valid flag and payload storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= {W{1'b0}};
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else begin
         valid <= valid;
         q     <= q;
      end
   end

endmodule

// File: rtl/ex_dm_pipe_reg.sv
// Elastic EX->DM pipeline register: main slot drives DM, skid slot absorbs
// the one beat already in flight when DM stalls.
module ex_dm_pipe_reg
   import cpu_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int REG_ADDR_W = 5,
   localparam int BE_W       = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  up_valid,
   output logic                  up_ready,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [DATA_WIDTH-1:0] store_data_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  mem_to_reg_in,
   input  logic                  reg_write_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic [1:0]            mem_size_in,
   output logic                  dn_valid,
   input  logic                  dn_ready,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] store_data_out,
   output logic                  mem_read_out,
   output logic                  mem_write_out,
   output logic                  mem_to_reg_out,
   output logic                  reg_write_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic [BE_W-1:0]       byte_en,
   output logic                  misaligned
);

   localparam int LANE_W = $clog2(BE_W);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] store_data;
      ctrl_t                 ctrl;
      logic [REG_ADDR_W-1:0] rd;
      logic [BE_W-1:0]       be;
      logic                  mis;
   } beat_t;

   localparam int BEAT_W = $bits(beat_t);

   // State is the pair (main_valid, skid_valid); 01 is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BAD   = 2'b01,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_e;

   logic [LANE_IDX_W-1:0] lane;
   beat_t                 in_beat;
   beat_t                 main_beat;
   logic [BEAT_W-1:0]     main_d;
   logic [BEAT_W-1:0]     main_q;
   logic [BEAT_W-1:0]     skid_q;
   logic                  main_valid;
   logic                  skid_valid;
   logic                  main_load;
   logic                  main_clear;
   logic                  main_from_skid;
   logic                  skid_load;
   logic                  skid_clear;
   logic                  accept;
   logic                  deliver;
   state_e                state;

   // Build the incoming beat, including lane mask and alignment check.
   always_comb begin
      lane = {LANE_IDX_W{1'b0}};
      lane[LANE_W-1:0] = alu_result[LANE_W-1:0];
      in_beat.addr            = alu_result;
      in_beat.store_data      = store_data_in;
      in_beat.be              = BE_W'(byte_enable(mem_size_e'(mem_size_in), lane));
      in_beat.mis             = access_misaligned(mem_size_e'(mem_size_in), lane);
      in_beat.ctrl.mem_read   = mem_read_in  & ~in_beat.mis;
      in_beat.ctrl.mem_write  = mem_write_in & ~in_beat.mis;
      in_beat.ctrl.mem_to_reg = mem_to_reg_in;
      in_beat.ctrl.reg_write  = reg_write_in;
      in_beat.rd              = rd_in;
   end

   assign up_ready = ~skid_valid;
   assign accept   = up_valid & up_ready;
   assign deliver  = main_valid & dn_ready;
   assign state    = state_e'({main_valid, skid_valid});

   // Next-state decode expressed as slot load/clear strobes.
   always_comb begin
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
               end else begin
                  main_load = 1'b0;
               end
            end
            ST_ONE: begin
               if (deliver && accept) begin
                  main_load = 1'b1;
               end else if (deliver) begin
                  main_clear = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
               end else begin
                  main_load = 1'b0;
               end
            end
            ST_FULL: begin
               if (deliver) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
               end else begin
                  main_load = 1'b0;
               end
            end
            default: begin
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   assign main_d = main_from_skid ? skid_q : BEAT_W'(in_beat);

   skid_slot #(.W(BEAT_W)) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   skid_slot #(.W(BEAT_W)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (BEAT_W'(in_beat)),
      .valid (skid_valid),
      .q     (skid_q)
   );

   assign main_beat      = beat_t'(main_q);
   assign dn_valid       = main_valid;
   assign mem_addr       = main_beat.addr;
   assign store_data_out = main_beat.store_data;
   assign mem_read_out   = main_beat.ctrl.mem_read;
   assign mem_write_out  = main_beat.ctrl.mem_write;
   assign mem_to_reg_out = main_beat.ctrl.mem_to_reg;
   assign reg_write_out  = main_beat.ctrl.reg_write;
   assign rd_out         = main_beat.rd;
   assign byte_en        = main_beat.be;
   assign misaligned     = main_beat.mis;

endmodule
